mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous program/data RAM among three requesters: the CPU MEM stage (d), the CPU IF stage (i), and an external program loader/debug port (x).
- Sits between the 5-stage pipeline core and the RAM.
- Grants one access per cycle and returns read data one cycle after the grant.
- Produces stall indications the core uses to freeze the pipeline.

Parameters:
- AW, 8, address width (word addresses)
- DW, 16, data width
- MAX_WAIT, 4, consecutive denied cycles after which IF is promoted above the MEM stage (range 1..15)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- d_req  in  1  MEM-stage access request
- d_we  in  1  MEM-stage write (1) / read (0)
- d_addr  in  AW  MEM-stage address
- d_wdata  in  DW  MEM-stage store data
- d_gnt  out  1  MEM-stage request accepted this cycle
- d_rvalid  out  1  MEM-stage read data valid on rdata
- d_stall  out  1  d_req & ~d_gnt
- i_req  in  1  IF fetch request (read only)
- i_addr  in  AW  fetch address (pc)
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  instruction valid on rdata
- i_stall  out  1  i_req & ~i_gnt
- x_req  in  1  loader request
- x_we  in  1  loader write/read
- x_lock  in  1  loader requests exclusive burst ownership
- x_addr  in  AW  loader address
- x_wdata  in  DW  loader write data
- x_gnt  out  1  loader accepted this cycle
- x_rvalid  out  1  loader read data valid
- rdata  out  DW  shared read-return bus (registered copy of mem_rdata)
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid one cycle after mem_en & ~mem_we

Behaviour:
- Reset (asynchronous, while high):
  - All outputs are 0.
  - RR pointer points at i; wait counter is 0; lock state is UNLOCKED; pending-read tag is NONE.
  - A read in flight when reset asserts is discarded; no rvalid follows.
- Grant logic:
  - Combinational from the req inputs and the registered state.
  - Winner's gnt and mem_en/mem_we/mem_addr/mem_wdata are driven in the same cycle.
  - mem_we = winner's we (0 for i). With no winner, mem_en = 0 and mem_* hold 0.
- Priority, evaluated in order:
  1. LOCKED and x_req → x. In LOCKED state, d and i are never granted.
  2. wait counter == MAX_WAIT and i_req → i.
  3. d_req → d.
  4. i_req / x_req → round-robin by RR pointer. If only one requests, it wins.
- RR pointer:
  - Moves to x after an i grant and to i after an x grant.
  - Unchanged by d grants and promoted-i grants.
- Wait counter:
  - Increments when i_req & ~i_gnt, saturating at MAX_WAIT.
  - Clears on i_gnt or ~i_req.
- Lock FSM:
  - UNLOCKED → LOCKED: on the clock edge where x_gnt & x_lock.
  - LOCKED → UNLOCKED: when x_lock = 0. In that cycle arbitration already uses the UNLOCKED rules, so release is immediate.
  - LOCKED with x_req = 0 but x_lock = 1: no grants issued.
- Read return:
  - A granted read registers its owner tag.
  - Next cycle, exactly one of d/i/x_rvalid is high for one cycle and rdata = mem_rdata.
  - Write grants produce no rvalid. rdata holds its last value otherwise.
  - Back-to-back reads are fully pipelined: one grant and one return per cycle.
- Each requester must hold req/addr/we/wdata stable until its gnt.
- Only one access per cycle. A d write and an i read in the same cycle: d wins and i stalls.

Decomposition:
- Package mem_arb_pkg: AW/DW defaults, owner enum {OWN_NONE, OWN_D, OWN_I, OWN_X}, lock enum {UNLOCKED, LOCKED}.
- One natural sub-module, arb_wait_ctr: the saturating starvation counter with its promote output. Parameter MAX_WAIT; inputs req and gnt.

Test Plan:
- Reset mid-read: x read of 0x20 granted, reset asserted the next cycle → no x_rvalid, all outputs 0, pointer back at i.
- Lone i_req reads addr 0x05 with RAM[0x05] = 0xA5A5 → i_gnt in cycle N, i_rvalid with rdata = 0xA5A5 in N+1, i_stall = 0.
- d_req (write 0x1234 to 0x10) and i_req in the same cycle → d_gnt, mem_we = 1, i_stall = 1; i granted the next cycle.
- d_req held continuously with i_req, MAX_WAIT = 4 → i denied 4 cycles, then i_gnt in cycle 5 while d_stall = 1, then d resumes.
- i and x requesting continuously, no d → grants alternate i, x, i, x.
- x_lock = 1 with x writes 0x00..0x03 while d/i request → only x granted for 4 cycles. Dropping x_lock releases in the same cycle and d wins.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port RAM arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 16;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_D,
        OWN_I,
        OWN_X
    } owner_e;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus RAM port bundled for the arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic          d_stall;

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic          i_stall;

    logic          x_req;
    logic          x_we;
    logic          x_lock;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    logic          x_gnt;
    logic          x_rvalid;

    logic [DW-1:0] rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_stall,
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_stall,
        input  x_req, x_we, x_lock, x_addr, x_wdata,
        output x_gnt, x_rvalid,
        output rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_stall,
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_stall,
        output x_req, x_we, x_lock, x_addr, x_wdata,
        input  x_gnt, x_rvalid,
        input  rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/arb_wait_ctr.sv
// Saturating count of consecutive denied fetch cycles; promote_o once it hits MAX_WAIT.
module arb_wait_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic req_i,
    input  logic gnt_i,
    output logic promote_o
);

    localparam int unsigned CW = WAIT_W;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(MAX_WAIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign promote_o = (cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates MEM stage, IF stage and loader onto one single-port synchronous RAM.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    owner_e        win_c;
    owner_e        rr_q, rr_d;
    owner_e        tag_q, tag_d;
    lock_e         lock_q;
    logic          promote_c;
    logic          promoted_win_c;
    logic          locked_c;
    logic          we_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] wdata_c;
    logic [DW-1:0] rdata_q, rdata_d;

    arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clock     (clock),
        .reset     (reset),
        .req_i     (bus.i_req),
        .gnt_i     (bus.i_gnt),
        .promote_o (promote_c)
    );

    // Dropping x_lock releases the lock within the same cycle.
    assign locked_c = (lock_q == LOCKED) && bus.x_lock;

    always_comb begin : arbitrate
        win_c          = OWN_NONE;
        promoted_win_c = 1'b0;
        if (reset) begin
            win_c = OWN_NONE;
        end else if (locked_c) begin
            if (bus.x_req) win_c = OWN_X;
        end else if (promote_c && bus.i_req) begin
            win_c          = OWN_I;
            promoted_win_c = 1'b1;
        end else if (bus.d_req) begin
            win_c = OWN_D;
        end else if (bus.i_req && bus.x_req) begin
            win_c = rr_q;
        end else if (bus.i_req) begin
            win_c = OWN_I;
        end else if (bus.x_req) begin
            win_c = OWN_X;
        end
    end

    always_comb begin : mem_mux
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        case (win_c)
            OWN_D: begin
                we_c    = bus.d_we;
                addr_c  = bus.d_addr;
                wdata_c = bus.d_wdata;
            end
            OWN_I: begin
                addr_c = bus.i_addr;
            end
            OWN_X: begin
                we_c    = bus.x_we;
                addr_c  = bus.x_addr;
                wdata_c = bus.x_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin : next_state
        rr_d = rr_q;
        if (win_c == OWN_X) begin
            rr_d = OWN_I;
        end else if (win_c == OWN_I && !promoted_win_c) begin
            rr_d = OWN_X;
        end
        tag_d   = (win_c != OWN_NONE && !we_c) ? win_c : OWN_NONE;
        rdata_d = (tag_q != OWN_NONE) ? bus.mem_rdata : rdata_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q    <= OWN_I;
            tag_q   <= OWN_NONE;
            rdata_q <= '0;
            lock_q  <= UNLOCKED;
        end else begin
            rr_q    <= rr_d;
            tag_q   <= tag_d;
            rdata_q <= rdata_d;
            case (lock_q)
                UNLOCKED: if (win_c == OWN_X && bus.x_lock) lock_q <= LOCKED;
                LOCKED:   if (!bus.x_lock) lock_q <= UNLOCKED;
                default:  lock_q <= UNLOCKED;
            endcase
        end
    end

    assign bus.d_gnt     = (win_c == OWN_D);
    assign bus.i_gnt     = (win_c == OWN_I);
    assign bus.x_gnt     = (win_c == OWN_X);
    assign bus.d_stall   = bus.d_req && (win_c != OWN_D) && !reset;
    assign bus.i_stall   = bus.i_req && (win_c != OWN_I) && !reset;

    assign bus.mem_en    = (win_c != OWN_NONE);
    assign bus.mem_we    = we_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;

    // Read data is forwarded straight from the RAM in the return cycle, then held.
    assign bus.d_rvalid  = (tag_q == OWN_D);
    assign bus.i_rvalid  = (tag_q == OWN_I);
    assign bus.x_rvalid  = (tag_q == OWN_X);
    assign bus.rdata     = (tag_q != OWN_NONE) ? bus.mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural RAM.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    typedef struct packed {
        logic [2:0]    own;
        logic [DW-1:0] data;
    } ret_t;

    logic clock;
    logic reset;
    int   n_assert;
    int   n_fail;
    ret_t sb[$];

    logic [DW-1:0] ram [256];

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        case (a)
            8'h05:   return 16'hA5A5;
            8'h11:   return 16'h1111;
            default: return {a, ~a};
        endcase
    endfunction

    // Synchronous single-port RAM: data one cycle after a read enable.
    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) ram[k] <= init_word(8'(k));
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bus.d_req = req; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    endtask

    task automatic set_i(input logic req, input logic [AW-1:0] a);
        bus.i_req = req; bus.i_addr = a;
    endtask

    task automatic set_x(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bus.x_req = req; bus.x_we = we; bus.x_lock = lock; bus.x_addr = a; bus.x_wdata = wd;
    endtask

    task automatic idle();
        set_d(1'b0, 1'b0, '0, '0);
        set_i(1'b0, '0);
        set_x(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, " gnt"},    32'({bus.d_gnt, bus.i_gnt, bus.x_gnt}), 32'd0);
        chk({tag, " stall"},  32'({bus.d_stall, bus.i_stall}), 32'd0);
        chk({tag, " rvalid"}, 32'({bus.d_rvalid, bus.i_rvalid, bus.x_rvalid}), 32'd0);
        chk({tag, " rdata"},  32'(bus.rdata), 32'd0);
        chk({tag, " mem"},    32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'd0);
        chk({tag, " wdata"},  32'(bus.mem_wdata), 32'd0);
    endtask

    // One arbitration cycle: check grant, RAM port, stalls and any due return, then clock.
    task automatic cycle(input string tag, input logic [2:0] eg, input logic [DW-1:0] ed);
        logic [AW-1:0] ea;
        logic          ew;
        logic [DW-1:0] ewd;
        ret_t          e;
        #1;
        ea = '0; ew = 1'b0; ewd = '0;
        case (eg)
            3'b100: begin ea = bus.d_addr; ew = bus.d_we; ewd = bus.d_wdata; end
            3'b010: begin ea = bus.i_addr; end
            3'b001: begin ea = bus.x_addr; ew = bus.x_we; ewd = bus.x_wdata; end
            default: ;
        endcase
        chk({tag, " gnt"},   32'({bus.d_gnt, bus.i_gnt, bus.x_gnt}), 32'(eg));
        chk({tag, " stall"}, 32'({bus.d_stall, bus.i_stall}),
            32'({bus.d_req & ~eg[2], bus.i_req & ~eg[1]}));
        chk({tag, " mem"},   32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'({|eg, ew, ea}));
        chk({tag, " wdata"}, 32'(bus.mem_wdata), 32'(ewd));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " rvalid"}, 32'({bus.d_rvalid, bus.i_rvalid, bus.x_rvalid}), 32'(e.own));
            chk({tag, " rdata"},  32'(bus.rdata), 32'(e.data));
        end else begin
            chk({tag, " rvalid"}, 32'({bus.d_rvalid, bus.i_rvalid, bus.x_rvalid}), 32'd0);
        end
        if (eg != 3'b000 && !ew) sb.push_back('{own: eg, data: ed});
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        repeat (2) @(posedge clock);
        #1;
        zero_chk("reset");
        reset = 1'b0;

        // In-flight x read killed by reset; pointer returns to i.
        set_x(1'b1, 1'b0, 1'b0, 8'h20, '0);
        cycle("x_rd20", 3'b001, 16'h20DF);
        reset = 1'b1;
        idle();
        sb.delete();
        #1;
        zero_chk("rst_mid");
        @(posedge clock);
        #1;
        zero_chk("rst_hold");
        reset = 1'b0;

        // i and x contending: strict alternation starting at i.
        set_i(1'b1, 8'h05);
        set_x(1'b1, 1'b0, 1'b0, 8'h21, '0);
        cycle("rr_i0", 3'b010, 16'hA5A5);
        cycle("rr_x0", 3'b001, 16'h21DE);
        cycle("rr_i1", 3'b010, 16'hA5A5);
        cycle("rr_x1", 3'b001, 16'h21DE);
        idle();
        cycle("rr_drain", 3'b000, '0);

        // Lone fetch.
        set_i(1'b1, 8'h05);
        cycle("lone_i", 3'b010, 16'hA5A5);
        idle();
        cycle("lone_i_ret", 3'b000, '0);

        // MEM-stage write beats a fetch; fetch then reads the new word.
        set_d(1'b1, 1'b1, 8'h10, 16'h1234);
        set_i(1'b1, 8'h10);
        cycle("dw_vs_i", 3'b100, '0);
        set_d(1'b0, 1'b0, '0, '0);
        cycle("i_after_d", 3'b010, 16'h1234);
        idle();
        cycle("dw_drain", 3'b000, '0);

        // Starvation: four denials, promoted fetch, then d resumes.
        set_d(1'b1, 1'b0, 8'h11, '0);
        set_i(1'b1, 8'h05);
        for (int k = 0; k < 4; k++) cycle("promo_d", 3'b100, 16'h1111);
        cycle("promo_i", 3'b010, 16'hA5A5);
        cycle("promo_d_resume", 3'b100, 16'h1111);
        idle();
        cycle("promo_drain", 3'b000, '0);

        // Promoted grant left the pointer at x.
        set_i(1'b1, 8'h05);
        set_x(1'b1, 1'b0, 1'b0, 8'h21, '0);
        cycle("rr_keep_x", 3'b001, 16'h21DE);
        idle();
        cycle("rr_keep_drain", 3'b000, '0);

        // Locked loader burst excludes d and i.
        set_x(1'b1, 1'b1, 1'b1, 8'h00, 16'hC000);
        cycle("lk_x0", 3'b001, '0);
        set_d(1'b1, 1'b0, 8'h11, '0);
        set_i(1'b1, 8'h05);
        for (int k = 1; k < 4; k++) begin
            set_x(1'b1, 1'b1, 1'b1, 8'(k), 16'hC000 + 16'(k));
            cycle("lk_x", 3'b001, '0);
        end
        set_x(1'b0, 1'b0, 1'b1, '0, '0);
        set_i(1'b0, '0);
        cycle("lk_idle", 3'b000, '0);
        set_x(1'b0, 1'b0, 1'b0, '0, '0);
        set_i(1'b1, 8'h05);
        cycle("lk_release", 3'b100, 16'h1111);
        set_d(1'b0, 1'b0, '0, '0);
        cycle("lk_i", 3'b010, 16'hA5A5);
        idle();
        set_x(1'b1, 1'b0, 1'b0, 8'h02, '0);
        cycle("rd_x2", 3'b001, 16'hC002);
        idle();
        cycle("final_drain", 3'b000, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
